// File: rtl/udp_rx_pkg.sv
// -----------------------------------------------------------------------------
// udp_rx_pkg
// Shared types and protocol constants for the UDP/IPv4 receive parser.
//   state_t    : parser FSM states
//   constants  : preamble/SFD bytes, EtherType, IP protocol, header lengths
//   ones_add   : 16-bit ones'-complement addition (end-around carry)
// -----------------------------------------------------------------------------
package udp_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HEAD,
        IP_HEAD,
        UDP_HEAD,
        DATA,
        DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam int          ETH_HEAD_LEN  = 14;
    localparam int          UDP_HEAD_LEN  = 8;
    localparam int          PREAMBLE_LEN  = 7;

    // The folded sum never carries a second time: when the carry is set the
    // low 16 bits are at most 16'hFFFE.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/rx_byte_assembler.sv
// -----------------------------------------------------------------------------
// rx_byte_assembler
// Turns the MAC receive beat stream into bytes.
//   IN_W = 4 : nibbles paired low-then-high, byte_valid on the high nibble
//   IN_W = 8 : beats pass straight through
// byte_data/byte_valid are combinational so the parser registers its outputs
// exactly one cycle after the completing beat.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rxdv, rx_data       receive data valid and beat
//   byte_data           assembled byte
//   byte_valid          byte_data holds a complete byte this cycle
// -----------------------------------------------------------------------------
module rx_byte_assembler #(
    parameter int IN_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rxdv,
    input  logic [IN_W-1:0] rx_data,
    output logic [7:0]      byte_data,
    output logic            byte_valid
);

    generate
        if (IN_W == 8) begin : g_byte
            assign byte_data  = rx_data;
            assign byte_valid = rxdv;
        end else begin : g_nibble
            logic       phase;
            logic [3:0] lo_nib;

            // phase restarts on every rxdv-low gap so a frame always begins
            // with its low nibble
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    phase  <= 1'b0;
                    lo_nib <= 4'd0;
                end else if (!rxdv) begin
                    phase  <= 1'b0;
                end else begin
                    phase <= ~phase;
                    if (!phase) begin
                        lo_nib <= rx_data;
                    end
                end
            end

            assign byte_data  = {rx_data, lo_nib};
            assign byte_valid = rxdv & phase;
        end
    endgenerate

endmodule

// File: rtl/udp_rx_parser.sv
// -----------------------------------------------------------------------------
// udp_rx_parser
// Receive-side UDP/IPv4 frame parser. Checks preamble/SFD, Ethernet, IPv4 and
// UDP headers and delivers the UDP payload as big-endian OUT_W-bit words.
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   eth_rxdv, eth_rx_data  MAC receive stream (IN_W-bit beats)
//   rec_data_en          one-cycle strobe, rec_data valid
//   rec_data             payload word, first byte in the MSBs
//   rec_end              strobe with the frame's last rec_data_en
//   rec_data_num         payload byte count, updated with rec_end
//   rec_src_ip           sender IP, updated with rec_end
//   rec_src_port         sender UDP port, updated with rec_end
//   rec_err              strobe: rxdv lost while payload was arriving
// -----------------------------------------------------------------------------
module udp_rx_parser
    import udp_rx_pkg::*;
#(
    parameter int          IN_W            = 4,
    parameter int          OUT_W           = 32,
    parameter logic [47:0] BOARD_MAC       = 48'h12_34_56_78_9A_BC,
    parameter logic [31:0] BOARD_IP        = {8'd169, 8'd254, 8'd1, 8'd23},
    parameter logic [15:0] BOARD_PORT      = 16'd1234,
    parameter bit          PORT_FILTER_EN  = 1'b1,
    parameter bit          ENABLE_CHECKSUM = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             eth_rxdv,
    input  logic [IN_W-1:0]  eth_rx_data,
    output logic             rec_data_en,
    output logic [OUT_W-1:0] rec_data,
    output logic             rec_end,
    output logic [15:0]      rec_data_num,
    output logic [31:0]      rec_src_ip,
    output logic [15:0]      rec_src_port,
    output logic             rec_err
);

    localparam int BPW = OUT_W / 8;

    logic [7:0]       byte_data;
    logic             byte_valid;
    state_t           state, state_n;
    logic [15:0]      cnt;
    logic [7:0]       prev_byte;
    logic [47:0]      mac;
    logic [3:0]       ihl;
    logic [15:0]      total_len;
    logic [7:0]       proto;
    logic [31:0]      src_ip, dst_ip;
    logic [15:0]      csum;
    logic [15:0]      src_port, dst_port, udp_len, payload_len, pcnt;
    logic [2:0]       bcnt;
    logic [OUT_W-1:0] word_sr;

    logic             emit, emit_end, abort, zero_len;

    rx_byte_assembler #(.IN_W(IN_W)) u_byte_asm (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .rxdv       (eth_rxdv),
        .rx_data    (eth_rx_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid)
    );

    // Header field helpers: each 16-bit field completes on its odd byte as
    // {previous byte, current byte}.
    logic [15:0]      pair, hdr_bytes, csum_n, pcnt_n;
    logic [31:0]      dst_ip_n;
    logic             ip_last, mac_ok, ip_ok, port_ok, data_last, word_full;
    logic [OUT_W-1:0] word_n, justified;
    logic [5:0]       shamt;

    assign pair      = {prev_byte, byte_data};
    assign hdr_bytes = {10'd0, ihl, 2'b00};
    assign ip_last   = (cnt == hdr_bytes - 16'd1);
    assign csum_n    = cnt[0] ? ones_add(csum, pair) : csum;
    assign dst_ip_n  = (cnt >= 16'd16 && cnt <= 16'd19) ? {dst_ip[23:0], byte_data} : dst_ip;
    assign mac_ok    = (mac == BOARD_MAC) || (mac == 48'hFFFF_FFFF_FFFF);
    assign ip_ok     = (proto == IP_PROTO_UDP) && (dst_ip_n == BOARD_IP)
                    && (!ENABLE_CHECKSUM || csum_n == 16'hFFFF)
                    && (total_len >= hdr_bytes + 16'(UDP_HEAD_LEN));
    assign port_ok   = !PORT_FILTER_EN || (dst_port == BOARD_PORT);

    assign pcnt_n    = pcnt + 16'd1;
    assign data_last = (pcnt_n == payload_len);
    assign word_full = (bcnt == 3'(BPW - 1));
    assign word_n    = (word_sr << 8) | OUT_W'(byte_data);
    // a short final word is left-justified; a full word shifts by zero
    assign shamt     = {3'(BPW - 1) - bcnt, 3'b000};
    assign justified = word_n << shamt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        emit     = 1'b0;
        emit_end = 1'b0;
        abort    = 1'b0;
        zero_len = 1'b0;
        if (!eth_rxdv) begin
            state_n = IDLE;
            abort   = (state == DATA);
        end else if (byte_valid) begin
            case (state)
                IDLE: begin
                    state_n = (byte_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                end
                PREAMBLE: begin
                    // the first 0x55 was consumed in IDLE
                    if (cnt < 16'(PREAMBLE_LEN - 1)) begin
                        if (byte_data != PREAMBLE_BYTE) state_n = DROP;
                    end else begin
                        state_n = (byte_data == SFD_BYTE) ? ETH_HEAD : DROP;
                    end
                end
                ETH_HEAD: begin
                    if (cnt == 16'(ETH_HEAD_LEN - 1)) begin
                        state_n = (mac_ok && pair == ETH_TYPE_IPV4) ? IP_HEAD : DROP;
                    end
                end
                IP_HEAD: begin
                    if (cnt == 16'd0) begin
                        if (byte_data[7:4] != 4'd4 || byte_data[3:0] < 4'd5) state_n = DROP;
                    end else if (ip_last) begin
                        state_n = ip_ok ? UDP_HEAD : DROP;
                    end
                end
                UDP_HEAD: begin
                    if (cnt == 16'(UDP_HEAD_LEN - 1)) begin
                        if (!port_ok || udp_len < 16'(UDP_HEAD_LEN)) begin
                            state_n = DROP;
                        end else if (udp_len == 16'(UDP_HEAD_LEN)) begin
                            emit     = 1'b1;
                            emit_end = 1'b1;
                            zero_len = 1'b1;
                            state_n  = DROP;
                        end else begin
                            state_n = DATA;
                        end
                    end
                end
                DATA: begin
                    emit     = word_full || data_last;
                    emit_end = data_last;
                    if (data_last) state_n = DROP;
                end
                default: state_n = DROP;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt          <= '0;
            prev_byte    <= '0;
            mac          <= '0;
            ihl          <= '0;
            total_len    <= '0;
            proto        <= '0;
            src_ip       <= '0;
            dst_ip       <= '0;
            csum         <= '0;
            src_port     <= '0;
            dst_port     <= '0;
            udp_len      <= '0;
            payload_len  <= '0;
            pcnt         <= '0;
            bcnt         <= '0;
            word_sr      <= '0;
            rec_data_en  <= 1'b0;
            rec_end      <= 1'b0;
            rec_err      <= 1'b0;
            rec_data     <= '0;
            rec_data_num <= '0;
            rec_src_ip   <= '0;
            rec_src_port <= '0;
        end else begin
            rec_data_en <= emit;
            rec_end     <= emit_end;
            rec_err     <= abort;

            // cnt is the byte index within the current header section
            if (state_n != state) begin
                cnt <= '0;
            end else if (byte_valid) begin
                cnt <= cnt + 16'd1;
            end

            if (byte_valid) begin
                prev_byte <= byte_data;
                case (state)
                    ETH_HEAD: begin
                        if (cnt < 16'd6) mac <= {mac[39:0], byte_data};
                    end
                    IP_HEAD: begin
                        csum   <= (cnt == 16'd0) ? 16'd0 : csum_n;
                        dst_ip <= dst_ip_n;
                        if (cnt == 16'd0) ihl       <= byte_data[3:0];
                        if (cnt == 16'd3) total_len <= pair;
                        if (cnt == 16'd9) proto     <= byte_data;
                        if (cnt >= 16'd12 && cnt <= 16'd15) src_ip <= {src_ip[23:0], byte_data};
                    end
                    UDP_HEAD: begin
                        if (cnt == 16'd1) src_port <= pair;
                        if (cnt == 16'd3) dst_port <= pair;
                        if (cnt == 16'd5) udp_len  <= pair;
                        if (cnt == 16'd7) begin
                            payload_len <= udp_len - 16'(UDP_HEAD_LEN);
                            pcnt        <= '0;
                            bcnt        <= '0;
                            word_sr     <= '0;
                        end
                    end
                    DATA: begin
                        pcnt <= pcnt_n;
                        if (emit) begin
                            word_sr <= '0;
                            bcnt    <= '0;
                        end else begin
                            word_sr <= word_n;
                            bcnt    <= bcnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end

            // output registers
            if (emit) begin
                rec_data <= zero_len ? '0 : justified;
            end
            if (emit_end) begin
                rec_data_num <= zero_len ? 16'd0 : payload_len;
                rec_src_ip   <= src_ip;
                rec_src_port <= src_port;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// -----------------------------------------------------------------------------
// tb_udp_rx_parser
// Two parser instances: dut_a (nibble input, 32-bit words, checksum checked,
// port filter on) and dut_b (byte input, 16-bit words, port filter on).
// Frames are built from a vector table; delivered words, end/err strobes,
// latency, byte count and sender fields are compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_udp_rx_parser;

    localparam logic [47:0] BMAC = 48'h12_34_56_78_9A_BC;
    localparam logic [31:0] BIP  = 32'hA9FE_0117;
    localparam logic [31:0] SIP  = 32'h0A00_0005;
    localparam int          HDR  = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_dv, b_dv;
    logic [3:0]  a_rx;
    logic [7:0]  b_rx;
    logic        a_en, a_end, a_err, b_en, b_end, b_err;
    logic [31:0] a_data, a_sip, b_sip;
    logic [15:0] b_data, a_num, b_num, a_sport, b_sport;

    udp_rx_parser #(.IN_W(4), .OUT_W(32), .PORT_FILTER_EN(1'b1), .ENABLE_CHECKSUM(1'b1)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .eth_rxdv(a_dv), .eth_rx_data(a_rx),
        .rec_data_en(a_en), .rec_data(a_data), .rec_end(a_end), .rec_data_num(a_num),
        .rec_src_ip(a_sip), .rec_src_port(a_sport), .rec_err(a_err));

    udp_rx_parser #(.IN_W(8), .OUT_W(16), .PORT_FILTER_EN(1'b1), .ENABLE_CHECKSUM(1'b0)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .eth_rxdv(b_dv), .eth_rx_data(b_rx),
        .rec_data_en(b_en), .rec_data(b_data), .rec_end(b_end), .rec_data_num(b_num),
        .rec_src_ip(b_sip), .rec_src_port(b_sport), .rec_err(b_err));

    typedef struct {
        bit               dut;
        logic [47:0]      mac;
        logic [31:0]      ip;
        logic [15:0]      dport;
        logic [15:0]      sport;
        int               n;
        logic [7:0]       base;
        logic [7:0]       step;
        bit               bad_csum;
        int               cut;
        int               exp_words;
        logic [2:0][31:0] w;
        bit               exp_end;
        bit               exp_err;
    } vec_t;

    vec_t        vecs[13];
    logic [7:0]  frame[$];
    logic [31:0] got[$];
    int          n_end, end_idx, end_cyc, n_err, last_cyc;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_en) got.push_back(a_data);
        if (b_en) got.push_back({16'h0, b_data});
        if (a_end || b_end) begin
            n_end++;
            end_idx = got.size() - 1;
            end_cyc = cyc;
        end
        if (a_err || b_err) n_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit dut, logic [47:0] mac, logic [31:0] ip, logic [15:0] dport,
                                logic [15:0] sport, int n, logic [7:0] base, logic [7:0] step,
                                bit bad, int cut, int nw, logic [31:0] w0, logic [31:0] w1,
                                logic [31:0] w2, bit e, bit er);
        vec_t v;
        v.dut = dut; v.mac = mac; v.ip = ip; v.dport = dport; v.sport = sport; v.n = n;
        v.base = base; v.step = step; v.bad_csum = bad; v.cut = cut; v.exp_words = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.exp_end = e; v.exp_err = er;
        return v;
    endfunction

    task automatic build(input vec_t v);
        logic [7:0]  ip[20];
        logic [47:0] smac;
        logic [15:0] tl, ul, cs;
        logic [31:0] s;
        smac = 48'h02_00_00_00_00_01;
        tl = 16'(28 + v.n);
        ul = 16'(8 + v.n);
        frame.delete();
        repeat (7) frame.push_back(8'h55);
        frame.push_back(8'hD5);
        for (int i = 0; i < 6; i++) frame.push_back(v.mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(smac[47-8*i -: 8]);
        frame.push_back(8'h08);
        frame.push_back(8'h00);
        ip = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'd17,
               8'h00, 8'h00, SIP[31:24], SIP[23:16], SIP[15:8], SIP[7:0],
               v.ip[31:24], v.ip[23:16], v.ip[15:8], v.ip[7:0]};
        s = 32'd0;
        for (int i = 0; i < 10; i++) s = s + {16'd0, ip[2*i], ip[2*i+1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        cs = ~s[15:0];
        if (v.bad_csum) cs = cs ^ 16'h0001;
        ip[10] = cs[15:8];
        ip[11] = cs[7:0];
        for (int i = 0; i < 20; i++) frame.push_back(ip[i]);
        frame.push_back(v.sport[15:8]); frame.push_back(v.sport[7:0]);
        frame.push_back(v.dport[15:8]); frame.push_back(v.dport[7:0]);
        frame.push_back(ul[15:8]);      frame.push_back(ul[7:0]);
        frame.push_back(8'h00);         frame.push_back(8'h00);
        for (int i = 0; i < v.n; i++) frame.push_back(8'(v.base + v.step * 8'(i)));
        frame.push_back(8'hDE); frame.push_back(8'hAD); frame.push_back(8'hBE); frame.push_back(8'hEF);
    endtask

    task automatic drive_bytes(input bit dut, input int stop, input int last_idx);
        for (int i = 0; i < stop; i++) begin
            if (!dut) begin
                a_dv = 1'b1;
                a_rx = frame[i][3:0];
                @(posedge clk); #1;
                a_rx = frame[i][7:4];
                if (i == last_idx) last_cyc = cyc;
                @(posedge clk); #1;
            end else begin
                b_dv = 1'b1;
                b_rx = frame[i];
                if (i == last_idx) last_cyc = cyc;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic clear_mon();
        got.delete();
        n_end = 0; n_err = 0; end_idx = -1; end_cyc = -1; last_cyc = -100;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        clear_mon();
        build(v);
        drive_bytes(v.dut, (v.cut >= 0) ? HDR + v.cut : frame.size(), HDR + v.n - 1);
        a_dv = 1'b0; b_dv = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tag = $sformatf("v%0d", idx);
        check({tag, "_words"}, got.size(), v.exp_words);
        for (int k = 0; k < v.exp_words && k < got.size(); k++)
            check($sformatf("%s_word%0d", tag, k), got[k], v.w[k]);
        check({tag, "_end_cnt"}, n_end, v.exp_end ? 1 : 0);
        check({tag, "_err_cnt"}, n_err, v.exp_err ? 1 : 0);
        if (v.exp_end) begin
            check({tag, "_end_pos"}, end_idx, v.exp_words - 1);
            check({tag, "_latency"}, end_cyc, last_cyc + 1);
            check({tag, "_num"}, v.dut ? b_num : a_num, 16'(v.n));
            check({tag, "_src_ip"}, v.dut ? b_sip : a_sip, SIP);
            check({tag, "_src_port"}, v.dut ? b_sport : a_sport, v.sport);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        a_dv = 1'b0; b_dv = 1'b0; a_rx = '0; b_rx = '0;
        vecs[0]  = mk(0, BMAC, BIP, 16'd1234, 16'd4000, 12, 8'h01, 8'h01, 0, -1, 3,
                      32'h01020304, 32'h05060708, 32'h090A0B0C, 1, 0);
        vecs[1]  = mk(0, BMAC, BIP, 16'd1234, 16'd4001, 5, 8'hAA, 8'h11, 0, -1, 2,
                      32'hAABBCCDD, 32'hEE000000, 32'h0, 1, 0);
        vecs[2]  = mk(0, BMAC, 32'hA9FE0118, 16'd1234, 16'd4000, 4, 8'h01, 8'h01, 0, -1, 0,
                      32'h0, 32'h0, 32'h0, 0, 0);
        vecs[3]  = mk(0, 48'h12_34_56_78_9A_BD, BIP, 16'd1234, 16'd4000, 4, 8'h01, 8'h01, 0, -1, 0,
                      32'h0, 32'h0, 32'h0, 0, 0);
        vecs[4]  = mk(0, 48'hFFFF_FFFF_FFFF, BIP, 16'd1234, 16'd4002, 4, 8'h10, 8'h10, 0, -1, 1,
                      32'h10203040, 32'h0, 32'h0, 1, 0);
        vecs[5]  = mk(0, BMAC, BIP, 16'd1234, 16'd4000, 4, 8'h01, 8'h01, 1, -1, 0,
                      32'h0, 32'h0, 32'h0, 0, 0);
        vecs[6]  = mk(0, BMAC, BIP, 16'd1234, 16'd4000, 12, 8'h01, 8'h01, 0, 6, 1,
                      32'h01020304, 32'h0, 32'h0, 0, 1);
        vecs[7]  = mk(0, BMAC, BIP, 16'd1234, 16'd4003, 12, 8'h21, 8'h01, 0, -1, 3,
                      32'h21222324, 32'h25262728, 32'h292A2B2C, 1, 0);
        vecs[8]  = mk(0, BMAC, BIP, 16'd1234, 16'd4004, 0, 8'h00, 8'h00, 0, -1, 1,
                      32'h00000000, 32'h0, 32'h0, 1, 0);
        vecs[9]  = mk(0, BMAC, BIP, 16'd1235, 16'd4000, 4, 8'h01, 8'h01, 0, -1, 0,
                      32'h0, 32'h0, 32'h0, 0, 0);
        vecs[10] = mk(0, BMAC, BIP, 16'd1234, 16'd4005, 3, 8'h07, 8'h01, 0, -1, 1,
                      32'h07080900, 32'h0, 32'h0, 1, 0);
        vecs[11] = mk(1, BMAC, BIP, 16'd1235, 16'd5000, 5, 8'h01, 8'h01, 0, -1, 0,
                      32'h0, 32'h0, 32'h0, 0, 0);
        vecs[12] = mk(1, BMAC, BIP, 16'd1234, 16'd5000, 5, 8'h01, 8'h01, 0, -1, 3,
                      32'h00000102, 32'h00000304, 32'h00000500, 1, 0);

        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_en", a_en, 0);
        check("rst_a_end", a_end, 0);
        check("rst_a_err", a_err, 0);
        check("rst_a_data", a_data, 0);
        check("rst_a_num", a_num, 0);
        check("rst_a_sip", a_sip, 0);
        check("rst_a_sport", a_sport, 0);
        check("rst_b_data", b_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // reset in the middle of a payload: outputs clear at once, no strobes
        clear_mon();
        build(vecs[0]);
        drive_bytes(1'b0, HDR + 6, -1);
        check("mid_pre_words", got.size(), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", a_data, 0);
        check("mid_rst_num", a_num, 0);
        check("mid_rst_sip", a_sip, 0);
        check("mid_rst_sport", a_sport, 0);
        a_dv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_strobes", got.size(), 1);
        check("mid_rst_err", n_err, 0);
        check("mid_rst_end", n_end, 0);

        // recovery after reset, then rec_data holds the last word
        run_vec(100, vecs[0]);
        repeat (5) @(posedge clk);
        #1;
        check("hold_data", a_data, 32'h090A0B0C);
        check("hold_num", a_num, 16'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Parametrised receive-side UDP/IPv4 frame parser: the next generation of the board's UDP receive path. Takes the MAC-side receive stream (4-bit nibble or 8-bit byte beats), checks preamble/SFD, Ethernet, IPv4 and UDP headers, and delivers UDP payload as big-endian OUT_W-bit words with a last-word flag, byte count, sender IP/port and an error/abort status. Sits between the PHY/MAC receive interface and the user-side receive buffer.

## Interface
- IN_W, 4, input beat width; 4 (nibble, low nibble first) or 8.
- OUT_W, 32, payload word width; 8, 16 or 32.
- BOARD_MAC, 48'h12_34_56_78_9A_BC, accepted destination MAC (broadcast FF..FF also accepted).
- BOARD_IP, {8'd169,8'd254,8'd1,8'd23}, accepted destination IP.
- BOARD_PORT, 16'd1234, accepted destination UDP port.
- PORT_FILTER_EN, 1, 1 = drop frames whose destination port differs from BOARD_PORT.
- ENABLE_CHECKSUM, 0, 1 = verify IPv4 header checksum before payload.

- sys_clk  in  1  receive clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- eth_rxdv  in  1  receive data valid, framing the whole frame.
- eth_rx_data  in  IN_W  receive beat.
- rec_data_en  out  1  one-cycle strobe: rec_data valid.
- rec_data  out  OUT_W  payload word, first byte in MSBs.
- rec_end  out  1  one-cycle strobe coincident with the frame's last rec_data_en.
- rec_data_num  out  16  payload byte count; valid from rec_end until next frame's first rec_data_en.
- rec_src_ip  out  32  sender IP, valid with rec_end.
- rec_src_port  out  16  sender UDP port, valid with rec_end.
- rec_err  out  1  one-cycle strobe: frame aborted after payload began (rxdv lost early).

## Operation
- Byte assembly: IN_W=4 pairs nibbles low-then-high into one byte; IN_W=8 passes through. Byte counter resets when eth_rxdv is low.
- FSM states: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, DATA, DROP.
- IDLE -> PREAMBLE on first byte with rxdv high. PREAMBLE requires 7×0x55 then 0xD5; otherwise -> DROP.
- ETH_HEAD (14 bytes): dest MAC must equal BOARD_MAC or broadcast; EtherType must be 0x0800; else DROP.
- IP_HEAD: version 4; IHL from byte 0 (≥5), options skipped; total length latched; protocol 17; dest IP = BOARD_IP; src IP latched. ENABLE_CHECKSUM: 16-bit ones'-complement sum of header words must be 16'hFFFF; else DROP.
- UDP_HEAD (8 bytes): src port latched; dest port checked when PORT_FILTER_EN; payload length = UDP length − 8. Length < 8 -> DROP; payload 0 -> rec_end pulse with rec_data_en, rec_data = 0, rec_data_num = 0.
- DATA: bytes shifted into word MSB-first; word emitted every OUT_W/8 bytes. Final partial word left-justified, low bytes zero. After last payload byte -> DROP (Ethernet padding and FCS ignored).
- DROP -> IDLE when eth_rxdv low. Any state -> IDLE on rxdv low; in DATA this pulses rec_err, no rec_end.
- Arithmetic: lengths 16-bit unsigned; payload byte counter 16-bit, no wrap (max 65527).

## Timing
- Reset: rec_data_en, rec_end, rec_err = 0; rec_data, rec_data_num, rec_src_ip, rec_src_port = 0; FSM = IDLE.
- rec_data_en/rec_end asserted the cycle after the beat completing the word/frame is sampled (1-cycle latency, registered outputs).
- rec_data holds between strobes. No backpressure; downstream must accept every strobe.
- IN_W=4: strobes at most every 2·OUT_W/8 cycles; IN_W=8: every OUT_W/8 cycles.
- Back-to-back frames need ≥1 rxdv-low cycle; rxdv low and final byte in the same cycle: final byte is not counted.
- Reset mid-frame: outputs cleared immediately, no strobes.

## Structure
- Package udp_rx_pkg: state enum, PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, ETH_TYPE_IPV4 16'h0800, IP_PROTO_UDP 8'd17, ETH_HEAD_LEN 14, UDP_HEAD_LEN 8.
- Sub-module rx_byte_assembler (IN_W -> byte + byte_valid); parser and word packer in top.

## Test plan
- IN_W=4, OUT_W=32, 12-byte payload 01..0C to BOARD_MAC/IP -> 3 strobes 01020304, 05060708, 090A0B0C; rec_end with third; rec_data_num = 12.
- OUT_W=32, 5-byte payload AA BB CC DD EE -> AABBCCDD, then EE000000 with rec_end; rec_data_num = 5.
- Dest IP 169.254.1.24, then MAC 12:34:56:78:9A:BD -> zero strobes; broadcast MAC with correct IP -> accepted.
- ENABLE_CHECKSUM=1, corrupted header checksum -> zero strobes; correct checksum -> normal delivery.
- rxdv dropped after 6 of 12 payload bytes -> one strobe, rec_err pulse, no rec_end; next valid frame delivered correctly.
- IN_W=8, OUT_W=16, PORT_FILTER_EN=1, dest port 1235 -> dropped; port 1234, src port 5000 -> delivered, rec_src_port = 5000.
